alu_result_display: RTL and testbench

//  Downstream display stage for the 3-bit ALU: consumes the 6-bit result bus and the 3-bit op select.

---
 rtl/alu_result_display.sv | 188 ++++++++++++++++++
 tb/tb_alu_result_display.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// Display stage for the 3-bit ALU: converts the 6-bit result to BCD with a
// sequential double-dabble and scans op symbol, blank, tens and units on a 4-digit 7-segment display.
module alu_result_display #(
  parameter int SCAN_DIV      = 50000,
  parameter bit COMMON_ANODE  = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] result,
  input  logic [2:0] op,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy,
  output logic       bcd_valid
);

  localparam int CNT_W = (SCAN_DIV <= 2) ? 1 : $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [5:0]       result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [5:0]       bin_q, bin_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic [2:0]       op_disp_q, op_disp_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [13:0]      shifted;
  logic [6:0]       seg_raw;
  logic [3:0]       an_raw;

  function automatic logic [7:0] dd_adjust(input logic [7:0] b);
    logic [3:0] lo, hi;
    lo = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
    hi = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
    return {hi, lo};
  endfunction

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] op_glyph(input logic [2:0] o);
    case (o)
      3'd0:    return 7'h77;
      3'd1:    return 7'h6D;
      3'd2:    return 7'h73;
      3'd3:    return 7'h5E;
      3'd4:    return 7'h50;
      default: return 7'h40;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    op_d      = op_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    tens_d    = tens_q;
    units_d   = units_q;
    op_disp_d = op_disp_q;
    valid_d   = 1'b0;
    busy_d    = (state_q != ST_IDLE);
    shifted   = '0;
    case (state_q)
      ST_IDLE: begin
        if ({result, op} != {result_q, op_q}) begin
          result_d = result;
          op_d     = op;
          bcd_d    = '0;
          bin_d    = result;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shifted = {dd_adjust(bcd_q), bin_q} << 1;
        bcd_d   = shifted[13:6];
        bin_d   = shifted[5:0];
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_d = ST_DONE;
      end
      ST_DONE: begin
        tens_d    = bcd_q[7:4];
        units_d   = bcd_q[3:0];
        op_disp_d = op_q;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Glyphs are latched only at the start of a slot so a mid-slot update waits for the next digit.
  always_comb begin
    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    idx_d      = (scan_cnt_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
    seg_raw    = 7'h00;
    an_raw     = 4'b0000;
    case (idx_q)
      2'd0: begin
        seg_raw = digit_glyph(units_q);
        an_raw  = 4'b0001;
      end
      2'd1: begin
        seg_raw = (BLANK_LEADING && tens_q == 4'd0) ? 7'h00 : digit_glyph(tens_q);
        an_raw  = 4'b0010;
      end
      2'd2: an_raw = 4'b0100;
      default: begin
        seg_raw = op_glyph(op_disp_q);
        an_raw  = 4'b1000;
      end
    endcase
    seg_d = seg_q;
    an_d  = an_q;
    if (scan_cnt_q == '0) begin
      seg_d = COMMON_ANODE ? ~seg_raw : seg_raw;
      an_d  = COMMON_ANODE ? ~an_raw : an_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      op_q       <= '0;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      op_disp_q  <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= COMMON_ANODE ? 7'h7F : 7'h00;
      an_q       <= COMMON_ANODE ? 4'hF : 4'h0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      op_q       <= op_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      op_disp_q  <= op_disp_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign busy      = busy_q;
  assign bcd_valid = valid_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with SCAN_DIV=4, common-anode, leading blank on and off.
module tb_alu_result_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] result = '0;
  logic [2:0] op = '0;
  logic [6:0] seg, seg_nb;
  logic [3:0] an, an_nb;
  logic       busy, busy_nb, bcd_valid, valid_nb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_result_display #(.SCAN_DIV(4), .COMMON_ANODE(1'b1), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .op(op),
    .seg(seg), .an(an), .busy(busy), .bcd_valid(bcd_valid)
  );

  alu_result_display #(.SCAN_DIV(4), .COMMON_ANODE(1'b1), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .result(result), .op(op),
    .seg(seg_nb), .an(an_nb), .busy(busy_nb), .bcd_valid(valid_nb)
  );

  typedef struct {
    logic [5:0] result;
    logic [2:0] op;
    logic [6:0] tens;
    logic [6:0] units;
    logic [6:0] opg;
    logic [6:0] tens_nb;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic scan_capture(output logic [6:0] u, output logic [6:0] t, output logic [6:0] b,
                              output logic [6:0] o, output logic [6:0] t_nb);
    u = 7'h55; t = 7'h55; b = 7'h55; o = 7'h55; t_nb = 7'h55;
    repeat (20) tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      case (an)
        4'hE: u = seg;
        4'hD: begin t = seg; t_nb = seg_nb; end
        4'hB: b = seg;
        4'h7: o = seg;
        default: ;
      endcase
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (bcd_valid) ok = 1'b1;
    end
  endtask

  initial begin
    logic [9:0] busy_tr, val_tr;
    logic [6:0] cu, ct, cb, co, ctn;
    logic [3:0] an_exp[4];
    int pulses, first_p, second_p;
    bit ok, valid_seen;

    vecs[0] = '{6'd45, 3'd2, 7'h19, 7'h12, 7'h0C, 7'h19};
    vecs[1] = '{6'd63, 3'd0, 7'h02, 7'h30, 7'h08, 7'h02};
    vecs[2] = '{6'd7,  3'd0, 7'h7F, 7'h78, 7'h08, 7'h40};
    vecs[3] = '{6'd0,  3'd5, 7'h7F, 7'h40, 7'h3F, 7'h40};
    vecs[4] = '{6'd10, 3'd3, 7'h79, 7'h40, 7'h21, 7'h79};
    vecs[5] = '{6'd58, 3'd4, 7'h12, 7'h00, 7'h2F, 7'h12};
    vecs[6] = '{6'd19, 3'd1, 7'h79, 7'h10, 7'h12, 7'h79};
    an_exp[0] = 4'hE; an_exp[1] = 4'hD; an_exp[2] = 4'hB; an_exp[3] = 4'h7;

    // Reset state
    repeat (3) tick();
    check("reset_seg", seg, 7'h7F);
    check("reset_an", an, 4'hF);
    check("reset_busy", busy, 1'b0);
    check("reset_valid", bcd_valid, 1'b0);

    // Idle after reset with matching inputs: scan order and glyphs
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (busy !== 1'b0) check("idle_busy", busy, 1'b0);
      if (k == 1 || k == 5 || k == 9 || k == 13 || k == 17)
        check($sformatf("idle_an_k%0d", k), an, an_exp[((k - 1) / 4) % 4]);
      if (k == 1)  check("idle_units", seg, 7'h40);
      if (k == 5)  begin check("idle_tens", seg, 7'h7F); check("idle_tens_nb", seg_nb, 7'h40); end
      if (k == 9)  check("idle_blank", seg, 7'h7F);
      if (k == 13) check("idle_op", seg, 7'h08);
    end

    // Table-driven conversions
    for (int v = 0; v < 7; v++) begin
      result = vecs[v].result;
      op     = vecs[v].op;
      busy_tr = '0;
      val_tr  = '0;
      for (int k = 0; k < 10; k++) begin
        tick();
        busy_tr[k] = busy;
        val_tr[k]  = bcd_valid;
      end
      check($sformatf("v%0d_busy_trace", v), busy_tr, 10'h0FE);
      check($sformatf("v%0d_valid_trace", v), val_tr, 10'h080);
      scan_capture(cu, ct, cb, co, ctn);
      check($sformatf("v%0d_units", v), cu, vecs[v].units);
      check($sformatf("v%0d_tens", v), ct, vecs[v].tens);
      check($sformatf("v%0d_blank", v), cb, 7'h7F);
      check($sformatf("v%0d_op", v), co, vecs[v].opg);
      check($sformatf("v%0d_tens_nb", v), ctn, vecs[v].tens_nb);
    end

    // Input changes mid-conversion: 10 then 20 on cycle 3
    result = 6'd10;
    op     = 3'd0;
    pulses = 0; first_p = -1; second_p = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 3) result = 6'd20;
      if (bcd_valid) begin
        pulses++;
        if (pulses == 1) begin
          first_p = k;
          check("mid_first_tens", dut.tens_q, 4'd1);
          check("mid_first_units", dut.units_q, 4'd0);
        end else if (pulses == 2) second_p = k;
      end
    end
    check("mid_pulse_count", pulses, 2);
    check("mid_first_cycle", first_p, 7);
    check("mid_second_cycle", second_p, 15);
    scan_capture(cu, ct, cb, co, ctn);
    check("mid_final_tens", ct, 7'h24);
    check("mid_final_units", cu, 7'h40);

    // Reset during SHIFT aborts the conversion of 50
    result = 6'd50;
    valid_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bcd_valid) valid_seen = 1'b1;
      if (k == 3) check("abort_busy_pre", busy, 1'b1);
    end
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bcd_valid) valid_seen = 1'b1;
      if (k == 0) begin
        check("abort_seg", seg, 7'h7F);
        check("abort_an", an, 4'hF);
        check("abort_busy", busy, 1'b0);
      end
    end
    check("abort_no_valid", valid_seen, 1'b0);
    rst_n = 1'b1;
    wait_valid(ok);
    check("abort_reconvert", ok, 1'b1);
    scan_capture(cu, ct, cb, co, ctn);
    check("abort_tens", ct, 7'h12);
    check("abort_units", cu, 7'h40);
    check("abort_op", co, 7'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
